tsv_frame_tx: RTL and testbench
===============================

Name: tsv_frame_tx

Overview:
- Downstream stage of the layer self-test FSM.
- Captures the 32-bit sort/ID word the FSM presents with its transmit strobe, and serializes it onto the single-bit inter-layer TSV line toward the next die.
- Latches the 4-bit power level carried in the word to set the TSV driver strength for that frame.
- Reports busy/done to the layer controller and counts strobes it had to drop.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit (>=2).
- GUARD_BITS, 2, idle-high bit periods appended after the stop bit before the next frame may start (>=0).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_valid  input  1  transmit request level from the self-test FSM; a frame starts on its rising edge.
- tx_data  input  32  frame word {4'b1010, power[3:0], chip_id[3:0], next_id[3:0], 16'hBEEF}.
- tsv_tx  output  1  serial TSV line; idle high.
- tsv_drv  output  4  driver strength select; holds tx_data[27:24] captured at frame start.
- busy  output  1  high from the capture cycle through the last guard cycle.
- done  output  1  one-cycle pulse on the final cycle of a frame.
- drop_cnt  output  DROP_W  saturating count of rising edges rejected while busy.

Behaviour:
- Reset: tsv_tx=1, tsv_drv=4'b0001, busy=0, done=0, drop_cnt=0, state=IDLE, edge register=0, shift register=0.
- Edge detect: rise = tx_valid & ~tx_valid_q, where tx_valid_q is the registered tx_valid. Holding tx_valid high never retriggers.
- States: IDLE, START, DATA, PAR (only with the optional feature), STOP, GUARD.
- IDLE -> START on rise:
  - shift reg <= tx_data; tsv_drv <= tx_data[27:24].
  - busy goes high the cycle after the edge is sampled.
  - tsv_tx goes 0 in the same cycle START is entered.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a bit-clock counter that resets on every state change.
- START: tsv_tx=0; then -> DATA.
- DATA:
  - 32 bits, LSB first; tsv_tx = shreg[0], shifted right at the end of each bit period.
  - A 6-bit bit counter runs 0..31.
  - After bit 31 -> PAR if the feature is enabled, else -> STOP.
- STOP: tsv_tx=1; then -> GUARD, or -> IDLE if GUARD_BITS=0.
- GUARD: tsv_tx=1 for GUARD_BITS periods; then -> IDLE.
- done is high on the last cycle before returning to IDLE; busy is also high in that cycle.
- Frame length without parity: (34+GUARD_BITS)*CLKS_PER_BIT cycles of busy.
- A rise seen in any state other than IDLE, including the done cycle, is dropped:
  - drop_cnt increments and saturates at all-ones.
  - The frame in flight is unaffected.
- tsv_drv holds its value until the next accepted frame.
- tx_data changes after capture have no effect.
- Reset mid-frame: all outputs return to reset values immediately; tsv_tx goes high asynchronously. A tx_valid already high at reset release produces no frame until it falls and rises again.
- Outputs are driven from registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: TSV_PARITY_EN.
- Defined: the PAR state follows DATA and sends one even-parity bit (XOR of the 32 captured bits) for CLKS_PER_BIT cycles. Frame becomes (35+GUARD_BITS)*CLKS_PER_BIT cycles.
- Undefined: there is no PAR state, and no parity logic is synthesized.

Test Plan:
- Reset, then idle for 20 cycles -> tsv_tx=1, busy=0, done=0, tsv_drv=4'b0001, drop_cnt=0.
- tx_data=32'hA312BEEF, single-cycle tx_valid pulse, CLKS_PER_BIT=4, GUARD_BITS=2, parity off:
  - tsv_tx low for 4 cycles, then bits 1,1,1,1,0,1,1,1,... (0xBEEF LSB first) at 4 cycles each.
  - tsv_drv=4'h3.
  - busy high for 144 cycles; done pulses once on the 144th.
- Same word with TSV_PARITY_EN -> a parity bit of 1 (popcount 19) follows data bit 31; busy lasts 148 cycles.
- Hold tx_valid high for 300 cycles -> exactly one frame is sent; drop_cnt stays 0.
- Second rise at cycle 50 of a frame, and another coincident with done -> both dropped; drop_cnt=2; the first frame is bit-exact.
- Assert rst_n low at data bit 10 -> tsv_tx=1 and busy=0 immediately. After release with tx_valid held high, no frame is sent until tx_valid deasserts and reasserts.

Source files
------------

// File: rtl/tsv_frame_tx_if.sv
// Handshake and serial-line bundle between the layer self-test FSM and tsv_frame_tx.
// The self-test FSM side uses the master modport; the serializer uses the slave modport.
interface tsv_frame_tx_if #(
    parameter int DROP_W = 8
);
    logic              tx_valid;
    logic [31:0]       tx_data;
    logic              tsv_tx;
    logic [3:0]        tsv_drv;
    logic              busy;
    logic              done;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output tx_valid, tx_data,
        input  tsv_tx, tsv_drv, busy, done, drop_cnt
    );

    modport slave (
        input  tx_valid, tx_data,
        output tsv_tx, tsv_drv, busy, done, drop_cnt
    );
endinterface

// File: rtl/tsv_frame_tx.sv
// Serializes the self-test sort/ID word onto the single-bit TSV line: start, 32 data bits LSB first,
// stop and idle-high guard periods. Defining TSV_PARITY_EN adds an even-parity bit after the data.
module tsv_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int GUARD_BITS   = 2,
    parameter int DROP_W       = 8
) (
    input logic           clk,
    input logic           rst_n,
    tsv_frame_tx_if.slave bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_PENULT = CW'(CLKS_PER_BIT - 2);

`ifdef TSV_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GUARD} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GUARD} state_t;
`endif

    state_t            state_reg;
    logic [CW-1:0]     clk_cnt_reg;
    logic [5:0]        bit_cnt_reg;
    logic [GW-1:0]     guard_cnt_reg;
    logic [31:0]       shreg_reg;
    logic              tx_valid_q_reg;
    logic              armed_reg;
    logic              tsv_tx_reg;
    logic [3:0]        tsv_drv_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
`ifdef TSV_PARITY_EN
    logic              parity_reg;
`endif

    logic rise;
    logic bit_end;
    logic last_guard;
    logic final_state;
    logic done_arm;

    // armed_reg keeps a level already high at reset release from looking like a new request
    assign rise     = bus.tx_valid & ~tx_valid_q_reg & armed_reg;
    assign bit_end  = (clk_cnt_reg == CLK_LAST);

    generate
        if (GUARD_BITS > 0) begin : g_guard
            assign last_guard  = (guard_cnt_reg == GW'(GUARD_BITS - 1));
            assign final_state = (state_reg == GUARD) && last_guard;
        end else begin : g_no_guard
            assign last_guard  = 1'b1;
            assign final_state = (state_reg == STOP);
        end
    endgenerate

    // done is registered, so it is raised one cycle ahead of the frame's final cycle
    assign done_arm = final_state && (clk_cnt_reg == CLK_PENULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            clk_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            guard_cnt_reg  <= '0;
            shreg_reg      <= '0;
            tx_valid_q_reg <= 1'b0;
            armed_reg      <= 1'b0;
            tsv_tx_reg     <= 1'b1;
            tsv_drv_reg    <= 4'b0001;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            drop_cnt_reg   <= '0;
`ifdef TSV_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            tx_valid_q_reg <= bus.tx_valid;
            armed_reg      <= armed_reg | ~bus.tx_valid;
            done_reg       <= done_arm;

            if (rise && (state_reg != IDLE) && (drop_cnt_reg != {DROP_W{1'b1}}))
                drop_cnt_reg <= drop_cnt_reg + 1'b1;

            if (state_reg != IDLE)
                clk_cnt_reg <= bit_end ? '0 : clk_cnt_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_reg   <= START;
                        clk_cnt_reg <= '0;
                        shreg_reg   <= bus.tx_data;
                        tsv_drv_reg <= bus.tx_data[27:24];
                        tsv_tx_reg  <= 1'b0;
                        busy_reg    <= 1'b1;
`ifdef TSV_PARITY_EN
                        parity_reg  <= ^bus.tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                        tsv_tx_reg  <= shreg_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg_reg   <= shreg_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'd31) begin
`ifdef TSV_PARITY_EN
                            state_reg  <= PAR;
                            tsv_tx_reg <= parity_reg;
`else
                            state_reg  <= STOP;
                            tsv_tx_reg <= 1'b1;
`endif
                        end else begin
                            tsv_tx_reg <= shreg_reg[1];
                        end
                    end
                end
`ifdef TSV_PARITY_EN
                PAR: begin
                    if (bit_end) begin
                        state_reg  <= STOP;
                        tsv_tx_reg <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (GUARD_BITS == 0) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg     <= GUARD;
                            guard_cnt_reg <= '0;
                        end
                    end
                end
                GUARD: begin
                    if (bit_end) begin
                        if (last_guard) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            guard_cnt_reg <= guard_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    tsv_tx_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tsv_tx   = tsv_tx_reg;
    assign bus.tsv_drv  = tsv_drv_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_tsv_frame_tx.sv
// Scoreboard bench for tsv_frame_tx: a frame-level model queues expected frames, a monitor
// compares each observed frame cycle by cycle against the ideal waveform.
module tb_tsv_frame_tx;

    localparam int CPB = 4;
    localparam int GB  = 2;
    localparam int DW  = 8;
`ifdef TSV_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 34 + GB + PB;
    localparam int FL = NB * CPB;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    tsv_frame_tx_if #(.DROP_W(DW)) bus_if ();

    tsv_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .GUARD_BITS  (GB),
        .DROP_W      (DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_frames = 0;

    // frame-level reference model state
    bit   m_prev;
    bit   m_armed;
    int   m_busy_end;
    int   m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Ideal line value during bit period k of a frame carrying d
    function automatic logic exp_bit(input logic [31:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 32) return d[k-1];
        if (PB == 1 && k == 33) return logic'($countones(d) % 2);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_prev     = 1'b0;
        m_armed    = 1'b0;
        m_busy_end = 0;
        m_drops    = 0;
    endtask

    // Drive one cycle of input, then let the model judge the edge that sampled it
    task automatic step(input bit v, input logic [31:0] d);
        bus_if.tx_valid = v;
        bus_if.tx_data  = d;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (v && !m_prev && m_armed) begin
                if (cyc > m_busy_end) begin
                    exp_q.push_back('{data: d, start: cyc});
                    m_busy_end = cyc + FL;
                end else if (m_drops < DROP_MAX) begin
                    m_drops++;
                end
            end
            if (!v) m_armed = 1'b1;
            m_prev = v;
        end
    endtask

    task automatic frame_check();
        exp_t e;
        int   wave_err = 0;
        int   busy_err = 0;
        int   done_err = 0;
        int   drv_err  = 0;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: busy rose at cycle %0d, expected no frame", cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("frame_start_cycle", cyc, e.start);
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst_n) begin
                $display("frame data=%h start=%0d aborted by reset", e.data, e.start);
                return;
            end
            if (bus_if.tsv_tx !== exp_bit(e.data, i / CPB)) wave_err++;
            if (bus_if.busy !== 1'b1) busy_err++;
            if (bus_if.done !== (i == FL - 1)) done_err++;
            if (bus_if.tsv_drv !== e.data[27:24]) drv_err++;
        end
        @(negedge clk);
        if (!rst_n) return;
        n_frames++;
        $display("frame %0d data=%h start=%0d wave_err=%0d busy_err=%0d done_err=%0d drv_err=%0d",
                 n_frames, e.data, e.start, wave_err, busy_err, done_err, drv_err);
        chk("frame_waveform_errors", wave_err, 0);
        chk("frame_busy_errors", busy_err, 0);
        chk("frame_done_errors", done_err, 0);
        chk("frame_tsv_drv_errors", drv_err, 0);
        chk("busy_after_frame", bus_if.busy, 1'b0);
    endtask

    initial begin : monitor
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.busy && !busy_prev) frame_check();
            busy_prev = bus_if.busy;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int t0;
        bit v;
        int len;

        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (20) step(1'b0, 32'h0);
        chk("idle_tsv_tx", bus_if.tsv_tx, 1'b1);
        chk("idle_busy", bus_if.busy, 1'b0);
        chk("idle_done", bus_if.done, 1'b0);
        chk("idle_tsv_drv", bus_if.tsv_drv, 4'b0001);
        chk("idle_drop_cnt", bus_if.drop_cnt, 0);

        // Directed frame with a single-cycle strobe; tx_data scrambled after capture
        step(1'b1, 32'hA312BEEF);
        repeat (FL + 10) step(1'b0, $urandom);
        chk("directed_tsv_drv", bus_if.tsv_drv, 4'h3);
        chk("directed_drop_cnt", bus_if.drop_cnt, m_drops);

        // Level held high: one frame, no drops
        repeat (300) step(1'b1, 32'hA5C3BEEF);
        repeat (FL) step(1'b0, $urandom);
        chk("hold_high_drop_cnt", bus_if.drop_cnt, m_drops);

        // Rises at cycle 50 of a frame and on its done cycle are both dropped
        step(1'b1, 32'hA7C2BEEF);
        t0 = cyc;
        while (cyc < t0 + 49) step(1'b0, $urandom);
        step(1'b1, $urandom);
        while (cyc < t0 + FL - 1) step(1'b0, $urandom);
        step(1'b1, $urandom);
        repeat (FL + 5) step(1'b0, $urandom);
        chk("two_drops_drop_cnt", bus_if.drop_cnt, m_drops);
        chk("two_drops_model", m_drops, 2);

        // Random request levels and data
        repeat (40) begin
            v   = bit'($urandom_range(0, 1));
            len = $urandom_range(1, 60);
            repeat (len) step(v, {4'b1010, 28'($urandom)});
        end
        repeat (FL + 5) step(1'b0, $urandom);
        chk("random_drop_cnt", bus_if.drop_cnt, m_drops);

        // Toggle every cycle long enough to saturate the drop counter
        repeat (700) begin
            step(1'b1, {4'b1010, 28'($urandom)});
            step(1'b0, $urandom);
        end
        repeat (FL + 5) step(1'b0, $urandom);
        chk("saturate_drop_cnt", bus_if.drop_cnt, m_drops);
        chk("saturate_drop_cnt_max", bus_if.drop_cnt, DROP_MAX);

        // Reset asserted during data bit 10 (a zero bit), with tx_valid held high
        step(1'b1, 32'hA6C40000);
        t0 = cyc;
        while (cyc < t0 + CPB * 11 + 1) step(1'b1, $urandom);
        chk("pre_reset_tsv_tx", bus_if.tsv_tx, exp_bit(32'hA6C40000, 11));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_tsv_tx", bus_if.tsv_tx, 1'b1);
        chk("reset_busy", bus_if.busy, 1'b0);
        chk("reset_done", bus_if.done, 1'b0);
        chk("reset_tsv_drv", bus_if.tsv_drv, 4'b0001);
        chk("reset_drop_cnt", bus_if.drop_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Level still high after release: nothing may be sent until it falls and rises
        repeat (200) step(1'b1, $urandom);
        chk("post_reset_busy", bus_if.busy, 1'b0);
        chk("post_reset_drop_cnt", bus_if.drop_cnt, 0);
        step(1'b0, $urandom);
        step(1'b1, 32'hA9E1BEEF);
        repeat (FL + 10) step(1'b0, $urandom);
        chk("final_tsv_drv", bus_if.tsv_drv, 4'h9);
        chk("final_drop_cnt", bus_if.drop_cnt, m_drops);
        chk("expected_frames_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
